tl_buffer_ad: RTL and testbench
===============================

# tl_buffer_ad

Two-channel TileLink buffer stage that sits directly downstream of the 64-bit width-adapter stage, between it and the next crossbar/slave port. Inserts an independent FIFO queue on the A (request) channel and the D (response) channel, breaking all combinational valid/ready/data paths between in and out sides. Field widths match the adapter's outward port: 32-bit address, 64-bit data, 4-bit source.

## Interface
Parameters:
- DEPTH_A, 2, A-channel queue entries (≥1)
- DEPTH_D, 2, D-channel queue entries (≥1)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- auto_in_a_ready / auto_in_a_valid  out/in  1  upstream A handshake
- auto_in_a_bits_{opcode,param,size}  in  3 each
- auto_in_a_bits_source  in  4; auto_in_a_bits_address  in  32; auto_in_a_bits_mask  in  8; auto_in_a_bits_data  in  64; auto_in_a_bits_corrupt  in  1
- auto_in_d_ready / auto_in_d_valid  in/out  1  upstream D handshake
- auto_in_d_bits_{opcode,size}  out  3 each; auto_in_d_bits_source  out  4; auto_in_d_bits_denied  out  1; auto_in_d_bits_data  out  64; auto_in_d_bits_corrupt  out  1
- auto_out_a_*  mirror of auto_in_a_* with directions reversed (downstream A)
- auto_out_d_*  mirror of auto_in_d_* with directions reversed (downstream D)

## Operation
- Each channel: circular FIFO, DEPTH entries, write pointer, read pointer, occupancy count 0..DEPTH (width clog2(DEPTH+1)).
- A payload (opcode,param,size,source,address,mask,data,corrupt = 118 bits) enqueued from auto_in_a, dequeued to auto_out_a. D payload (opcode,size,source,denied,data,corrupt = 76 bits) enqueued from auto_out_d, dequeued to auto_in_d.
- enq fires when in-side valid && ready; deq fires when out-side valid && ready.
- Enq-side ready = (count != DEPTH). Deq-side valid = (count != 0). Deq payload = entry[read pointer].
- Count: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Pointers increment on their fire, wrap DEPTH−1 → 0 (non-power-of-two DEPTH legal).
- Channels fully independent; no ordering or source tracking between A and D.
- Payload bits pass unmodified; no field interpretation, no burst awareness.
- Protocol legality (valid stable until fire) is the upstream's duty; block does not check it.

## Timing
- Reset asserted (reset=0): count, pointers, all storage cleared asynchronously. Outputs during/after reset: auto_out_a_valid=0, auto_in_d_valid=0, auto_in_a_ready=1, auto_out_d_ready=1, all bits outputs 0.
- Latency: item enqueued at edge N is visible on deq side from cycle N+1 (min 1 cycle); no flow-through when empty.
- Throughput: DEPTH≥2 sustains one transfer/cycle per channel; DEPTH=1 sustains one per two cycles.
- Full: enq-side ready=0; simultaneous deq that cycle does not allow enq (no pipe bypass); ready returns the cycle after deq.
- Empty: deq-side valid=0; simultaneous enq does not produce valid same cycle.
- Simultaneous enq+deq with 0<count<DEPTH: count unchanged, both pointers advance.
- Ready/valid outputs are functions of registered count only — no combinational in→out path.
- Reset mid-operation: queued items discarded, state as above immediately on reset assertion; release is synchronous to next clock edge with no spurious fire.

## Structure
- Shared package tl_pkg: field width constants (address 32, data 64, mask 8, source 4, opcode/param/size 3), packed typedefs tl_a_t and tl_d_t matching field order above, TL opcode constants.
- One sub-module: tl_queue (parameters WIDTH, DEPTH; enq/deq valid/ready/bits), instantiated once per channel with packed payloads; top is wiring plus pack/unpack.

## Test plan
- Reset: hold reset=0 with random inputs → out_a_valid=0, in_d_valid=0, in_a_ready=1, all bits 0.
- Single A beat: Get opcode=4, size=3, source=5, address=0x8000_0040, mask=0xFF, out_a_ready=1 → appears on auto_out_a exactly one cycle later, bits identical, then valid drops.
- Back-pressure fill: out_a_ready=0, push 3 PutFull beats (data 0x1111…, 0x2222…, 0x3333…) → first two accepted, in_a_ready=0 on third; raise out_a_ready → emitted in order 0x1111…, 0x2222…, third accepted the cycle after first deq.
- Streaming: continuous valid/ready both sides for 100 D beats (AccessAckData opcode=1, incrementing data) → one beat/cycle, in order, zero bubbles after first.
- Simultaneous enq/deq at count=1 and at full (count=2): count stays 1 in first case; at full, enq blocked that cycle, count drops to 1.
- Reset mid-stream with 2 A entries queued → out_a_valid=0 immediately; after release no stale beat emitted; DEPTH_A=1 rerun shows alternate-cycle throughput.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared TileLink field widths, packed channel payloads and opcode constants
// for the 64-bit adapter-side buffer stage.
package tl_pkg;

   localparam int TL_ADDR_W   = 32;
   localparam int TL_DATA_W   = 64;
   localparam int TL_MASK_W   = 8;
   localparam int TL_SOURCE_W = 4;
   localparam int TL_OPCODE_W = 3;
   localparam int TL_PARAM_W  = 3;
   localparam int TL_SIZE_W   = 3;

   localparam logic [TL_OPCODE_W-1:0] TL_A_PUT_FULL_DATA    = 3'd0;
   localparam logic [TL_OPCODE_W-1:0] TL_A_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [TL_OPCODE_W-1:0] TL_A_ARITHMETIC_DATA  = 3'd2;
   localparam logic [TL_OPCODE_W-1:0] TL_A_LOGICAL_DATA     = 3'd3;
   localparam logic [TL_OPCODE_W-1:0] TL_A_GET              = 3'd4;
   localparam logic [TL_OPCODE_W-1:0] TL_A_INTENT           = 3'd5;
   localparam logic [TL_OPCODE_W-1:0] TL_D_ACCESS_ACK       = 3'd0;
   localparam logic [TL_OPCODE_W-1:0] TL_D_ACCESS_ACK_DATA  = 3'd1;
   localparam logic [TL_OPCODE_W-1:0] TL_D_HINT_ACK         = 3'd2;

   // Field order here fixes the bit layout of the queued words (118 bits).
   typedef struct packed {
      logic [TL_OPCODE_W-1:0] opcode;
      logic [TL_PARAM_W-1:0]  param;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic [TL_ADDR_W-1:0]   address;
      logic [TL_MASK_W-1:0]   mask;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_a_t;

   // 76-bit response payload.
   typedef struct packed {
      logic [TL_OPCODE_W-1:0] opcode;
      logic [TL_SIZE_W-1:0]   size;
      logic [TL_SOURCE_W-1:0] source;
      logic                   denied;
      logic [TL_DATA_W-1:0]   data;
      logic                   corrupt;
   } tl_d_t;

endpackage

// File: rtl/tl_queue.sv
// Circular FIFO with registered count; ready/valid depend only on the count,
// so no combinational path exists from either side to the other.
module tl_queue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enq_valid_i,
   output logic             enq_ready_o,
   input  logic [WIDTH-1:0] enq_bits_i,
   output logic             deq_valid_o,
   input  logic             deq_ready_i,
   output logic [WIDTH-1:0] deq_bits_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             enq_fire_s;
   logic             deq_fire_s;

   assign enq_ready_o = (cnt_q != CNT_FULL);
   assign deq_valid_o = (cnt_q != {CNT_W{1'b0}});
   assign deq_bits_o  = mem_q[rptr_q];
   assign enq_fire_s  = enq_valid_i && enq_ready_o;
   assign deq_fire_s  = deq_valid_o && deq_ready_i;

   // Pointer and occupancy next state; explicit wrap allows non-power-of-two depths.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (enq_fire_s) begin
         wptr_d = (wptr_q == PTR_LAST) ? {PTR_W{1'b0}} : wptr_q + 1'b1;
      end else begin
         wptr_d = wptr_q;
      end
      if (deq_fire_s) begin
         rptr_d = (rptr_q == PTR_LAST) ? {PTR_W{1'b0}} : rptr_q + 1'b1;
      end else begin
         rptr_d = rptr_q;
      end
      case ({enq_fire_s, deq_fire_s})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q <= {PTR_W{1'b0}};
         rptr_q <= {PTR_W{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Storage is cleared on reset so the idle deq-side bits read as zero.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
      end else if (enq_fire_s) begin
         mem_q[wptr_q] <= enq_bits_i;
      end else begin
         mem_q[wptr_q] <= mem_q[wptr_q];
      end
   end

endmodule

// File: rtl/tl_buffer_ad.sv
// Two-channel TileLink buffer: independent queues on A (in->out) and D (out->in),
// with the top doing only payload packing and unpacking.
module tl_buffer_ad
   import tl_pkg::*;
#(
   parameter int DEPTH_A = 2,
   parameter int DEPTH_D = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   auto_in_a_ready,
   input  logic                   auto_in_a_valid,
   input  logic [TL_OPCODE_W-1:0] auto_in_a_bits_opcode,
   input  logic [TL_PARAM_W-1:0]  auto_in_a_bits_param,
   input  logic [TL_SIZE_W-1:0]   auto_in_a_bits_size,
   input  logic [TL_SOURCE_W-1:0] auto_in_a_bits_source,
   input  logic [TL_ADDR_W-1:0]   auto_in_a_bits_address,
   input  logic [TL_MASK_W-1:0]   auto_in_a_bits_mask,
   input  logic [TL_DATA_W-1:0]   auto_in_a_bits_data,
   input  logic                   auto_in_a_bits_corrupt,
   input  logic                   auto_in_d_ready,
   output logic                   auto_in_d_valid,
   output logic [TL_OPCODE_W-1:0] auto_in_d_bits_opcode,
   output logic [TL_SIZE_W-1:0]   auto_in_d_bits_size,
   output logic [TL_SOURCE_W-1:0] auto_in_d_bits_source,
   output logic                   auto_in_d_bits_denied,
   output logic [TL_DATA_W-1:0]   auto_in_d_bits_data,
   output logic                   auto_in_d_bits_corrupt,
   input  logic                   auto_out_a_ready,
   output logic                   auto_out_a_valid,
   output logic [TL_OPCODE_W-1:0] auto_out_a_bits_opcode,
   output logic [TL_PARAM_W-1:0]  auto_out_a_bits_param,
   output logic [TL_SIZE_W-1:0]   auto_out_a_bits_size,
   output logic [TL_SOURCE_W-1:0] auto_out_a_bits_source,
   output logic [TL_ADDR_W-1:0]   auto_out_a_bits_address,
   output logic [TL_MASK_W-1:0]   auto_out_a_bits_mask,
   output logic [TL_DATA_W-1:0]   auto_out_a_bits_data,
   output logic                   auto_out_a_bits_corrupt,
   output logic                   auto_out_d_ready,
   input  logic                   auto_out_d_valid,
   input  logic [TL_OPCODE_W-1:0] auto_out_d_bits_opcode,
   input  logic [TL_SIZE_W-1:0]   auto_out_d_bits_size,
   input  logic [TL_SOURCE_W-1:0] auto_out_d_bits_source,
   input  logic                   auto_out_d_bits_denied,
   input  logic [TL_DATA_W-1:0]   auto_out_d_bits_data,
   input  logic                   auto_out_d_bits_corrupt
);

   tl_a_t a_enq_s, a_deq_s;
   tl_d_t d_enq_s, d_deq_s;

   assign a_enq_s = {auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
                     auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
                     auto_in_a_bits_data, auto_in_a_bits_corrupt};
   assign d_enq_s = {auto_out_d_bits_opcode, auto_out_d_bits_size, auto_out_d_bits_source,
                     auto_out_d_bits_denied, auto_out_d_bits_data, auto_out_d_bits_corrupt};

   tl_queue #(.WIDTH($bits(tl_a_t)), .DEPTH(DEPTH_A)) u_queue_a (
      .clock       (clock),
      .reset       (reset),
      .enq_valid_i (auto_in_a_valid),
      .enq_ready_o (auto_in_a_ready),
      .enq_bits_i  (a_enq_s),
      .deq_valid_o (auto_out_a_valid),
      .deq_ready_i (auto_out_a_ready),
      .deq_bits_o  (a_deq_s)
   );

   tl_queue #(.WIDTH($bits(tl_d_t)), .DEPTH(DEPTH_D)) u_queue_d (
      .clock       (clock),
      .reset       (reset),
      .enq_valid_i (auto_out_d_valid),
      .enq_ready_o (auto_out_d_ready),
      .enq_bits_i  (d_enq_s),
      .deq_valid_o (auto_in_d_valid),
      .deq_ready_i (auto_in_d_ready),
      .deq_bits_o  (d_deq_s)
   );

   assign auto_out_a_bits_opcode  = a_deq_s.opcode;
   assign auto_out_a_bits_param   = a_deq_s.param;
   assign auto_out_a_bits_size    = a_deq_s.size;
   assign auto_out_a_bits_source  = a_deq_s.source;
   assign auto_out_a_bits_address = a_deq_s.address;
   assign auto_out_a_bits_mask    = a_deq_s.mask;
   assign auto_out_a_bits_data    = a_deq_s.data;
   assign auto_out_a_bits_corrupt = a_deq_s.corrupt;

   assign auto_in_d_bits_opcode   = d_deq_s.opcode;
   assign auto_in_d_bits_size     = d_deq_s.size;
   assign auto_in_d_bits_source   = d_deq_s.source;
   assign auto_in_d_bits_denied   = d_deq_s.denied;
   assign auto_in_d_bits_data     = d_deq_s.data;
   assign auto_in_d_bits_corrupt  = d_deq_s.corrupt;

endmodule

// File: tb/tb_tl_buffer_ad.sv
// Scoreboard bench for tl_buffer_ad: default-depth instance for data/flow checks,
// plus a DEPTH=1 instance for the alternate-cycle throughput check.
module tb_tl_buffer_ad;
   import tl_pkg::*;

   logic clock, reset;
   logic ia_valid, ia_ready, ia_corrupt;
   logic [2:0] ia_opcode, ia_param, ia_size;
   logic [3:0] ia_source;
   logic [31:0] ia_address;
   logic [7:0] ia_mask;
   logic [63:0] ia_data;
   logic oa_valid, oa_ready, oa_corrupt;
   logic [2:0] oa_opcode, oa_param, oa_size;
   logic [3:0] oa_source;
   logic [31:0] oa_address;
   logic [7:0] oa_mask;
   logic [63:0] oa_data;
   logic od_valid, od_ready, od_denied, od_corrupt;
   logic [2:0] od_opcode, od_size;
   logic [3:0] od_source;
   logic [63:0] od_data;
   logic id_valid, id_ready, id_denied, id_corrupt;
   logic [2:0] id_opcode, id_size;
   logic [3:0] id_source;
   logic [63:0] id_data;

   // single-entry instance signals
   logic ia_valid1, ia_ready1, oa_valid1, oa_ready1, oa_corrupt1, od_ready1;
   logic [2:0] oa_opcode1, oa_param1, oa_size1, id_opcode1, id_size1;
   logic [3:0] oa_source1, id_source1;
   logic [31:0] oa_address1;
   logic [7:0] oa_mask1;
   logic [63:0] oa_data1, id_data1;
   logic id_valid1, id_denied1, id_corrupt1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int d_pops = 0, d_first = 0, d_last = 0;
   logic [117:0] exp_a[$];
   logic [75:0]  exp_d[$];

   tl_buffer_ad dut (
      .clock(clock), .reset(reset),
      .auto_in_a_ready(ia_ready), .auto_in_a_valid(ia_valid),
      .auto_in_a_bits_opcode(ia_opcode), .auto_in_a_bits_param(ia_param),
      .auto_in_a_bits_size(ia_size), .auto_in_a_bits_source(ia_source),
      .auto_in_a_bits_address(ia_address), .auto_in_a_bits_mask(ia_mask),
      .auto_in_a_bits_data(ia_data), .auto_in_a_bits_corrupt(ia_corrupt),
      .auto_in_d_ready(id_ready), .auto_in_d_valid(id_valid),
      .auto_in_d_bits_opcode(id_opcode), .auto_in_d_bits_size(id_size),
      .auto_in_d_bits_source(id_source), .auto_in_d_bits_denied(id_denied),
      .auto_in_d_bits_data(id_data), .auto_in_d_bits_corrupt(id_corrupt),
      .auto_out_a_ready(oa_ready), .auto_out_a_valid(oa_valid),
      .auto_out_a_bits_opcode(oa_opcode), .auto_out_a_bits_param(oa_param),
      .auto_out_a_bits_size(oa_size), .auto_out_a_bits_source(oa_source),
      .auto_out_a_bits_address(oa_address), .auto_out_a_bits_mask(oa_mask),
      .auto_out_a_bits_data(oa_data), .auto_out_a_bits_corrupt(oa_corrupt),
      .auto_out_d_ready(od_ready), .auto_out_d_valid(od_valid),
      .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_size(od_size),
      .auto_out_d_bits_source(od_source), .auto_out_d_bits_denied(od_denied),
      .auto_out_d_bits_data(od_data), .auto_out_d_bits_corrupt(od_corrupt)
   );

   tl_buffer_ad #(.DEPTH_A(1), .DEPTH_D(1)) dut1 (
      .clock(clock), .reset(reset),
      .auto_in_a_ready(ia_ready1), .auto_in_a_valid(ia_valid1),
      .auto_in_a_bits_opcode(ia_opcode), .auto_in_a_bits_param(ia_param),
      .auto_in_a_bits_size(ia_size), .auto_in_a_bits_source(ia_source),
      .auto_in_a_bits_address(ia_address), .auto_in_a_bits_mask(ia_mask),
      .auto_in_a_bits_data(ia_data), .auto_in_a_bits_corrupt(ia_corrupt),
      .auto_in_d_ready(1'b1), .auto_in_d_valid(id_valid1),
      .auto_in_d_bits_opcode(id_opcode1), .auto_in_d_bits_size(id_size1),
      .auto_in_d_bits_source(id_source1), .auto_in_d_bits_denied(id_denied1),
      .auto_in_d_bits_data(id_data1), .auto_in_d_bits_corrupt(id_corrupt1),
      .auto_out_a_ready(oa_ready1), .auto_out_a_valid(oa_valid1),
      .auto_out_a_bits_opcode(oa_opcode1), .auto_out_a_bits_param(oa_param1),
      .auto_out_a_bits_size(oa_size1), .auto_out_a_bits_source(oa_source1),
      .auto_out_a_bits_address(oa_address1), .auto_out_a_bits_mask(oa_mask1),
      .auto_out_a_bits_data(oa_data1), .auto_out_a_bits_corrupt(oa_corrupt1),
      .auto_out_d_ready(od_ready1), .auto_out_d_valid(1'b0),
      .auto_out_d_bits_opcode(od_opcode), .auto_out_d_bits_size(od_size),
      .auto_out_d_bits_source(od_source), .auto_out_d_bits_denied(od_denied),
      .auto_out_d_bits_data(od_data), .auto_out_d_bits_corrupt(od_corrupt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_a(input logic [2:0] op, input logic [3:0] src, input logic [31:0] addr,
                          input logic [63:0] data);
      ia_valid = 1'b1; ia_opcode = op; ia_param = 3'd0; ia_size = 3'd3; ia_source = src;
      ia_address = addr; ia_mask = 8'hFF; ia_data = data; ia_corrupt = 1'b0;
   endtask

   // Pops before pushes, so a beat that flows through an empty queue has nothing to match.
   task automatic monitor_loop();
      logic [117:0] ea;
      logic [75:0]  ed;
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            if (oa_valid && oa_ready) begin
               if (exp_a.size() == 0) begin
                  chk("a_unexpected_beat", {10'd0, oa_opcode, oa_param, oa_size, oa_source, oa_address,
                      oa_mask, oa_data, oa_corrupt}, 128'hDEAD);
               end else begin
                  ea = exp_a.pop_front();
                  chk("a_payload", {10'd0, oa_opcode, oa_param, oa_size, oa_source, oa_address,
                      oa_mask, oa_data, oa_corrupt}, {10'd0, ea});
               end
            end
            if (id_valid && id_ready) begin
               if (d_pops == 0) d_first = cyc;
               d_last = cyc;
               d_pops++;
               if (exp_d.size() == 0) begin
                  chk("d_unexpected_beat", {52'd0, id_opcode, id_size, id_source, id_denied,
                      id_data, id_corrupt}, 128'hDEAD);
               end else begin
                  ed = exp_d.pop_front();
                  chk("d_payload", {52'd0, id_opcode, id_size, id_source, id_denied, id_data,
                      id_corrupt}, {52'd0, ed});
               end
            end
            if (ia_valid && ia_ready)
               exp_a.push_back({ia_opcode, ia_param, ia_size, ia_source, ia_address, ia_mask,
                                ia_data, ia_corrupt});
            if (od_valid && od_ready)
               exp_d.push_back({od_opcode, od_size, od_source, od_denied, od_data, od_corrupt});
         end
      end
   endtask

   initial begin
      int n_enq, n_deq;
      fork
         monitor_loop();
      join_none

      // Reset with random inputs
      reset = 1'b0;
      ia_valid1 = 1'b0; oa_ready1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         ia_valid = 1'($urandom); ia_opcode = 3'($urandom); ia_param = 3'($urandom);
         ia_size = 3'($urandom); ia_source = 4'($urandom); ia_address = $urandom;
         ia_mask = 8'($urandom); ia_data = {$urandom, $urandom}; ia_corrupt = 1'($urandom);
         oa_ready = 1'($urandom); id_ready = 1'($urandom); od_valid = 1'($urandom);
         od_opcode = 3'($urandom); od_size = 3'($urandom); od_source = 4'($urandom);
         od_denied = 1'($urandom); od_data = {$urandom, $urandom}; od_corrupt = 1'($urandom);
         tick();
         chk("rst_out_a_valid", 128'(oa_valid), 128'd0);
         chk("rst_in_d_valid", 128'(id_valid), 128'd0);
         chk("rst_in_a_ready", 128'(ia_ready), 128'd1);
         chk("rst_out_d_ready", 128'(od_ready), 128'd1);
      end
      chk("rst_out_a_bits", {10'd0, oa_opcode, oa_param, oa_size, oa_source, oa_address, oa_mask,
          oa_data, oa_corrupt}, 128'd0);
      chk("rst_in_d_bits", {52'd0, id_opcode, id_size, id_source, id_denied, id_data, id_corrupt},
          128'd0);
      ia_valid = 1'b0; od_valid = 1'b0; oa_ready = 1'b0; id_ready = 1'b0;
      reset = 1'b1;
      tick();

      // Single Get beat: one-cycle latency, no flow-through
      oa_ready = 1'b1;
      drive_a(TL_A_GET, 4'd5, 32'h8000_0040, 64'h0);
      chk("get_in_a_ready", 128'(ia_ready), 128'd1);
      chk("get_no_flow_through", 128'(oa_valid), 128'd0);
      tick();
      ia_valid = 1'b0;
      chk("get_valid_next_cycle", 128'(oa_valid), 128'd1);
      chk("get_address", 128'(oa_address), 128'h8000_0040);
      chk("get_source", 128'(oa_source), 128'd5);
      tick();
      chk("get_valid_drops", 128'(oa_valid), 128'd0);

      // Back-pressure fill and simultaneous enq/deq at full and at count=1
      oa_ready = 1'b0;
      drive_a(TL_A_PUT_FULL_DATA, 4'd1, 32'h0000_0100, 64'h1111_1111_1111_1111);
      tick();
      drive_a(TL_A_PUT_FULL_DATA, 4'd2, 32'h0000_0108, 64'h2222_2222_2222_2222);
      chk("fill_second_ready", 128'(ia_ready), 128'd1);
      tick();
      drive_a(TL_A_PUT_FULL_DATA, 4'd3, 32'h0000_0110, 64'h3333_3333_3333_3333);
      chk("fill_full_ready", 128'(ia_ready), 128'd0);
      tick();
      chk("fill_full_hold", 128'(ia_ready), 128'd0);
      oa_ready = 1'b1;
      chk("full_deq_no_bypass", 128'(ia_ready), 128'd0);
      chk("full_first_data", 128'(oa_data), 128'h1111_1111_1111_1111);
      tick();
      chk("ready_after_deq", 128'(ia_ready), 128'd1);
      chk("second_data", 128'(oa_data), 128'h2222_2222_2222_2222);
      tick();
      ia_valid = 1'b0;
      chk("cnt1_valid", 128'(oa_valid), 128'd1);
      chk("cnt1_ready", 128'(ia_ready), 128'd1);
      chk("third_data", 128'(oa_data), 128'h3333_3333_3333_3333);
      tick();
      chk("fill_drained", 128'(oa_valid), 128'd0);

      // Streaming 100 AccessAckData beats on D
      id_ready = 1'b1;
      od_valid = 1'b1; od_opcode = TL_D_ACCESS_ACK_DATA; od_size = 3'd3;
      od_denied = 1'b0; od_corrupt = 1'b0;
      for (int i = 0; i < 100; i++) begin
         od_source = 4'(i);
         od_data = 64'hD000_0000_0000_0000 + 64'(i);
         chk("stream_d_ready", 128'(od_ready), 128'd1);
         tick();
      end
      od_valid = 1'b0;
      tick(); tick();
      chk("stream_d_count", 128'(d_pops), 128'd100);
      chk("stream_d_no_bubbles", 128'(d_last - d_first), 128'd99);

      // Reset mid-stream with two A entries queued
      oa_ready = 1'b0;
      drive_a(TL_A_PUT_FULL_DATA, 4'd10, 32'h0000_0200, 64'hAAAA_AAAA_AAAA_AAAA);
      tick();
      drive_a(TL_A_PUT_FULL_DATA, 4'd11, 32'h0000_0208, 64'hBBBB_BBBB_BBBB_BBBB);
      tick();
      ia_valid = 1'b0;
      chk("mid_valid_before", 128'(oa_valid), 128'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_valid", 128'(oa_valid), 128'd0);
      chk("mid_rst_ready", 128'(ia_ready), 128'd1);
      chk("mid_rst_data", 128'(oa_data), 128'd0);
      exp_a.delete();
      oa_ready = 1'b1;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_stale", 128'(oa_valid), 128'd0);
      end

      // DEPTH_A=1 throughput: one transfer every other cycle
      n_enq = 0; n_deq = 0;
      ia_valid1 = 1'b1; oa_ready1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (oa_valid1) n_deq++;
         if (ia_ready1) n_enq++;
         tick();
      end
      ia_valid1 = 1'b0;
      chk("depth1_deq_count", 128'(n_deq), 128'd10);
      chk("depth1_enq_count", 128'(n_enq), 128'd10);

      tick();
      chk("a_scoreboard_empty", 128'(exp_a.size()), 128'd0);
      chk("d_scoreboard_empty", 128'(exp_d.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
